arx_round_sequencer: RTL and testbench

- Multi-cycle controller that drives the shared integer ALU through an ARX (add-rotate-xor) round sequence for the custom crypto extension.
- Sits beside the ALU operand muxes and issues one ALU operation per granted cycle using the existing 4-bit ALU control codes.
- Latches results back into internal a/d registers.
- The core owns the ALU by default; the sequencer uses it only when alu_grant is high.

---
 rtl/arx_round_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_arx_round_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arx_round_sequencer.sv
`timescale 1ns/1ps
// arx_round_sequencer: drives the shared integer ALU through ROUNDS add-xor-rotate rounds.
// Latency: done is high 3*ROUNDS+1 edges after the start-accept edge (edge itself counted), +1 per denied cycle.
// Backpressure: alu_grant low freezes state, working registers and ALU operand outputs; start is ignored while busy.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   start, a_in, b_in, d_in    sequence launch and initial operands (sampled only in IDLE)
//   alu_grant, alu_result      ALU ownership for this cycle and its combinational result
//   alu_req, alu_srca/srcb/ctrl  ALU request and operand/control drive (all registered)
//   busy, done, a_out, d_out   status and final results
//   abort                      present only with ARX_ABORT_EN; cancels a running sequence
//
// Optional feature macro: ARX_ABORT_EN (adds the abort input).
module arx_round_sequencer #(
  parameter int ROUNDS  = 4,
  parameter int ROT_AMT = 7,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic [XLEN-1:0] d_in,
  input  logic            alu_grant,
`ifdef ARX_ABORT_EN
  input  logic            abort,
`endif
  input  logic [XLEN-1:0] alu_result,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_srca,
  output logic [XLEN-1:0] alu_srcb,
  output logic [3:0]      alu_ctrl,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] a_out,
  output logic [XLEN-1:0] d_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_XOR  = 3'd2,
    S_ROT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0]  CTRL_ADD  = 4'b0000;
  localparam logic [3:0]  CTRL_XOR  = 4'b0100;
  localparam logic [3:0]  CTRL_ROTL = 4'b1101;
  localparam logic [7:0]  ROUNDS8   = 8'(ROUNDS);
  localparam logic [4:0]  ROT5      = ROT_AMT[4:0];

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] d_q, d_d;
  logic [7:0]      rnd_q, rnd_d;
  logic [XLEN-1:0] a_out_q, a_out_d;
  logic [XLEN-1:0] d_out_q, d_out_d;

  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] srca_q, srca_d;
  logic [XLEN-1:0] srcb_q, srcb_d;
  logic [3:0]      ctrl_q, ctrl_d;

  logic            abort_w;

`ifdef ARX_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Next-state and datapath register update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    rnd_d   = rnd_q;
    a_out_d = a_out_q;
    d_out_d = d_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          d_d     = d_in;
          rnd_d   = ROUNDS8;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        // abort outranks grant: nothing is written back on an aborted cycle
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (alu_grant) begin
          a_d     = alu_result;
          state_d = S_XOR;
        end
      end
      S_XOR: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (alu_grant) begin
          d_d     = alu_result;
          state_d = S_ROT;
        end
      end
      S_ROT: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (alu_grant) begin
          d_d   = alu_result;
          rnd_d = rnd_q - 8'd1;
          if (rnd_q == 8'd1) begin
            // Publish results on entry so they are visible during the DONE cycle.
            a_out_d = a_q;
            d_out_d = alu_result;
            state_d = S_DONE;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so that they always describe
  // the state the sequencer is in; a stalled cycle reproduces identical values.
  always_comb begin
    req_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    srca_d = '0;
    srcb_d = '0;
    ctrl_d = 4'b0000;

    unique case (state_d)
      S_ADD: begin
        req_d  = 1'b1;
        srca_d = a_d;
        srcb_d = b_d;
        ctrl_d = CTRL_ADD;
      end
      S_XOR: begin
        req_d  = 1'b1;
        srca_d = d_d;
        srcb_d = a_d;
        ctrl_d = CTRL_XOR;
      end
      S_ROT: begin
        req_d  = 1'b1;
        srca_d = d_d;
        srcb_d = XLEN'(ROT5);
        ctrl_d = CTRL_ROTL;
      end
      default: begin
        req_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      rnd_q   <= '0;
      a_out_q <= '0;
      d_out_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      srca_q  <= '0;
      srcb_q  <= '0;
      ctrl_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      rnd_q   <= rnd_d;
      a_out_q <= a_out_d;
      d_out_q <= d_out_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign alu_req  = req_q;
  assign alu_srca = srca_q;
  assign alu_srcb = srcb_q;
  assign alu_ctrl = ctrl_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign a_out    = a_out_q;
  assign d_out    = d_out_q;

endmodule

// File: tb/tb_arx_round_sequencer.sv
`timescale 1ns/1ps
module tb_arx_round_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2;
  logic [31:0] a_in, b_in, d_in;
  logic        alu_grant;
`ifdef ARX_ABORT_EN
  logic        abort;
`endif

  // DUT with ROUNDS=1
  logic        req1, busy1, done1;
  logic [31:0] srca1, srcb1, res1, aout1, dout1;
  logic [3:0]  ctrl1;
  // DUT with ROUNDS=2
  logic        req2, busy2, done2;
  logic [31:0] srca2, srcb2, res2, aout2, dout2;
  logic [3:0]  ctrl2;

  always #5 clk = ~clk;

  arx_round_sequencer #(.ROUNDS(1), .ROT_AMT(7), .XLEN(32)) u_r1 (
    .clk(clk), .reset(reset), .start(start1),
    .a_in(a_in), .b_in(b_in), .d_in(d_in), .alu_grant(alu_grant),
`ifdef ARX_ABORT_EN
    .abort(abort),
`endif
    .alu_result(res1), .alu_req(req1), .alu_srca(srca1), .alu_srcb(srcb1),
    .alu_ctrl(ctrl1), .busy(busy1), .done(done1), .a_out(aout1), .d_out(dout1)
  );

  arx_round_sequencer #(.ROUNDS(2), .ROT_AMT(7), .XLEN(32)) u_r2 (
    .clk(clk), .reset(reset), .start(start2),
    .a_in(a_in), .b_in(b_in), .d_in(d_in), .alu_grant(alu_grant),
`ifdef ARX_ABORT_EN
    .abort(1'b0),
`endif
    .alu_result(res2), .alu_req(req2), .alu_srca(srca2), .alu_srcb(srcb2),
    .alu_ctrl(ctrl2), .busy(busy2), .done(done2), .a_out(aout2), .d_out(dout2)
  );

  // Reference ALU: add, xor, rotate-left.
  function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
    logic [4:0] s;
    s = y[4:0];
    case (c)
      4'b0000: alu = x + y;
      4'b0100: alu = x ^ y;
      4'b1101: alu = (s == 5'd0) ? x : ((x << s) | (x >> (6'd32 - {1'b0, s})));
      default: alu = 32'h0;
    endcase
  endfunction

  always_comb res1 = alu(srca1, srcb1, ctrl1);
  always_comb res2 = alu(srca2, srcb2, ctrl2);

  // Observation mux: sel picks which instance the generic sequence task watches.
  logic        sel;
  logic        o_req, o_busy, o_done;
  logic [31:0] o_srca, o_srcb, o_aout, o_dout;
  logic [3:0]  o_ctrl;
  always_comb begin
    if (sel) begin
      o_req = req2; o_busy = busy2; o_done = done2; o_srca = srca2;
      o_srcb = srcb2; o_ctrl = ctrl2; o_aout = aout2; o_dout = dout2;
    end else begin
      o_req = req1; o_busy = busy1; o_done = done1; o_srca = srca1;
      o_srcb = srcb1; o_ctrl = ctrl1; o_aout = aout1; o_dout = dout1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        sel;     // 0: ROUNDS=1 instance, 1: ROUNDS=2 instance
    logic [31:0] a, b, d;
    logic [31:0] exp_a, exp_d;
    int          gmode;   // 0: grant always high, 1: grant on alternate cycles
  } vec_t;

  typedef struct {
    logic [31:0] a, d;
    int          lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] ctrl_exp [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e, got;
    int          cyc, denied, ops, rounds;
    logic        was_denied;
    logic [31:0] sa, sb;
    logic [3:0]  sc;
    rounds = v.sel ? 2 : 1;
    sel = v.sel;
    a_in = v.a; b_in = v.b; d_in = v.d;
    alu_grant = 1'b1;
    if (v.sel) start2 = 1'b1; else start1 = 1'b1;
    e.a = v.exp_a; e.d = v.exp_d; e.lat = 3 * rounds + 1;
    sb_q.push_back(e);
    tick();
    start1 = 1'b0; start2 = 1'b0;
    // Operand changes after acceptance must not matter.
    a_in = $urandom; b_in = $urandom; d_in = $urandom;
    cyc = 1; denied = 0; ops = 0;
    sa = '0; sb = '0; sc = '0;
    while (!o_done && cyc < 100) begin
      alu_grant = (v.gmode == 0) ? 1'b1 : ((cyc % 2) == 1);
      was_denied = o_req && !alu_grant;
      if (o_req && alu_grant) begin
        check("ctrl_seq", {28'h0, o_ctrl}, {28'h0, ctrl_exp[ops % 3]});
        ops++;
      end
      if (was_denied) begin
        denied++;
        sa = o_srca; sb = o_srcb; sc = o_ctrl;
      end
      tick();
      cyc++;
      if (was_denied) begin
        check("stall_srca", o_srca, sa);
        check("stall_srcb", o_srcb, sb);
        check("stall_ctrl", {28'h0, o_ctrl}, {28'h0, sc});
      end
    end
    alu_grant = 1'b1;
    check("done_seen", {31'h0, o_done}, 32'h1);
    if (o_done) begin
      got = sb_q.pop_front();
      check("a_out", o_aout, got.a);
      check("d_out", o_dout, got.d);
      check("latency", cyc, got.lat + denied);
      check("op_count", ops, 3 * rounds);
      check("busy_in_done", {31'h0, o_busy}, 32'h1);
    end
    tick();
    check("done_one_pulse", {31'h0, o_done}, 32'h0);
    check("busy_after", {31'h0, o_busy}, 32'h0);
    check("req_idle", {31'h0, o_req}, 32'h0);
  endtask

  vec_t vecs [5];
  int   dcnt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_exp[0] = 4'b0000; ctrl_exp[1] = 4'b0100; ctrl_exp[2] = 4'b1101;
    vecs[0] = '{sel: 1'b0, a: 32'h1, b: 32'h2, d: 32'h0, exp_a: 32'h3, exp_d: 32'h180, gmode: 0};
    vecs[1] = '{sel: 1'b0, a: 32'hFFFFFFFF, b: 32'h1, d: 32'h80000000, exp_a: 32'h0, exp_d: 32'h40, gmode: 0};
    vecs[2] = '{sel: 1'b1, a: 32'h1, b: 32'h2, d: 32'h0, exp_a: 32'h5, exp_d: 32'hC280, gmode: 1};
    vecs[3] = '{sel: 1'b0, a: 32'h12345678, b: 32'h11111111, d: 32'hA5A5A5A5, exp_a: 32'h23456789, exp_d: 32'h70611643, gmode: 1};
    vecs[4] = '{sel: 1'b1, a: 32'h1, b: 32'h2, d: 32'h0, exp_a: 32'h5, exp_d: 32'hC280, gmode: 0};

    sel = 1'b0; reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
    a_in = 32'h0; b_in = 32'h0; d_in = 32'h0; alu_grant = 1'b0;
`ifdef ARX_ABORT_EN
    abort = 1'b0;
`endif
    // Reset state; grant high while not requesting must be harmless.
    tick(); tick();
    alu_grant = 1'b1;
    tick();
    check("rst_req", {31'h0, req1}, 32'h0);
    check("rst_busy", {31'h0, busy1}, 32'h0);
    check("rst_done", {31'h0, done1}, 32'h0);
    check("rst_srca", srca1, 32'h0);
    check("rst_srcb", srcb1, 32'h0);
    check("rst_ctrl", {28'h0, ctrl1}, 32'h0);
    check("rst_aout", aout1, 32'h0);
    check("rst_dout", dout1, 32'h0);
    reset = 1'b0;
    tick(); tick();
    check("idle_req", {31'h0, req1}, 32'h0);
    check("idle_busy", {31'h0, busy2}, 32'h0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // start during XOR and in the DONE cycle are ignored; start right after is taken.
    sel = 1'b0; alu_grant = 1'b1;
    a_in = 32'h1; b_in = 32'h2; d_in = 32'h0;
    start1 = 1'b1;
    tick();                       // ADD
    start1 = 1'b0;
    check("s_busy_add", {31'h0, busy1}, 32'h1);
    check("s_srca_add", srca1, 32'h1);
    tick();                       // XOR
    check("s_ctrl_xor", {28'h0, ctrl1}, 32'h4);
    start1 = 1'b1;
    tick();                       // ROT
    start1 = 1'b0;
    check("s_ctrl_rot", {28'h0, ctrl1}, 32'hD);
    check("s_srcb_rot", srcb1, 32'h7);
    tick();                       // DONE
    check("s_done", {31'h0, done1}, 32'h1);
    check("s_aout", aout1, 32'h3);
    check("s_dout", dout1, 32'h180);
    check("s_done_srca", srca1, 32'h0);
    start1 = 1'b1;
    a_in = 32'hFFFFFFFF; b_in = 32'h1; d_in = 32'h80000000;
    tick();                       // IDLE: DONE-cycle start ignored
    check("s_no_redone", {31'h0, done1}, 32'h0);
    check("s_idle_busy", {31'h0, busy1}, 32'h0);
    check("s_hold_dout", dout1, 32'h180);
    tick();                       // accepted
    start1 = 1'b0;
    check("s_restart_busy", {31'h0, busy1}, 32'h1);
    check("s_restart_srca", srca1, 32'hFFFFFFFF);
    dcnt = 0;
    for (int k = 0; k < 3 && !done1; k++) tick();
    check("s_run2_done", {31'h0, done1}, 32'h1);
    check("s_run2_aout", aout1, 32'h0);
    check("s_run2_dout", dout1, 32'h40);
    tick();

    // Reset in ROT of round 1 on the ROUNDS=2 instance.
    sel = 1'b1;
    a_in = 32'h1; b_in = 32'h2; d_in = 32'h0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick(); tick();               // ROT
    check("r_in_rot", {28'h0, ctrl2}, 32'hD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_busy", {31'h0, busy2}, 32'h0);
    check("r_req", {31'h0, req2}, 32'h0);
    check("r_done", {31'h0, done2}, 32'h0);
    check("r_aout", aout2, 32'h0);
    check("r_dout", dout2, 32'h0);
    check("r_srca", srca2, 32'h0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done2) dcnt++;
    end
    check("r_no_done", dcnt, 0);

`ifdef ARX_ABORT_EN
    vecs[0].sel = 1'b0;
    run_vec(vecs[0]);
    a_in = 32'h7; b_in = 32'h9; d_in = 32'h3;
    start1 = 1'b1;
    tick();                       // ADD
    start1 = 1'b0;
    tick();                       // XOR
    abort = 1'b1;
    alu_grant = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", {31'h0, busy1}, 32'h0);
    check("ab_req", {31'h0, req1}, 32'h0);
    check("ab_done", {31'h0, done1}, 32'h0);
    check("ab_dout", dout1, 32'h180);
    check("ab_aout", aout1, 32'h3);
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done1) dcnt++;
    end
    check("ab_no_done", dcnt, 0);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
